// File: rtl/game_event_io.sv
// Synchronised, debounced game inputs with sticky edge flags, saturating counters,
// a packed regfile status word and a registered interrupt. Optional macro: GAME_FALL_EVENT_EN.
module game_event_io #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ch_in,
  input  logic [NUM_CH-1:0]       irq_mask,
  input  logic                    ack_wen,
  input  logic [NUM_CH-1:0]       ack_mask,
  input  logic [NUM_CH-1:0]       cnt_clr,
  output logic [NUM_CH-1:0]       level,
  output logic [NUM_CH-1:0]       rise_flag,
  output logic [NUM_CH*CNT_W-1:0] event_count,
  output logic [31:0]             status_word,
  output logic                    irq
);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("game_event_io: NUM_CH must be in 1..8");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("game_event_io: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("game_event_io: DEBOUNCE_CYCLES must be in 1..65535");
  end
  if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
    $error("game_event_io: CNT_W must be in 1..16");
  end

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] s;
  logic [DB_W-1:0]   db_cnt_q [NUM_CH];
  logic [DB_W-1:0]   db_cnt_d [NUM_CH];
  logic [NUM_CH-1:0] level_q, level_d;
  logic [NUM_CH-1:0] toggle, rise_p;
  logic [NUM_CH-1:0] ack_clr;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0] irq_src;
  logic              irq_q, irq_d;

`ifdef GAME_FALL_EVENT_EN
  logic [NUM_CH-1:0] fall_p;
  logic [NUM_CH-1:0] fall_q, fall_d;
`endif

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= ch_in;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Counter only runs while the synchronised input disagrees with the accepted
  // level; the toggle edge itself returns it to zero.
  always_comb begin
    toggle = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      db_cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) toggle[i] = 1'b1;
        else                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
    level_d = level_q ^ toggle;
    rise_p  = toggle & ~level_q;
  end

  // Edge pulses come straight from the toggle decision so flags and counters
  // update on the same edge as the level they describe.
  always_comb begin
    ack_clr = ack_wen ? ack_mask : '0;
    rise_d  = rise_p | (rise_q & ~ack_clr);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr[i])                        cnt_d[i] = '0;
      else if (rise_p[i] && cnt_q[i] != '1)  cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
`ifdef GAME_FALL_EVENT_EN
    fall_p  = toggle & level_q;
    fall_d  = fall_p | (fall_q & ~ack_clr);
    irq_src = rise_q | fall_q;
`else
    irq_src = rise_q;
`endif
    irq_d = |(irq_src & irq_mask);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        db_cnt_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      level_q <= '0;
      rise_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      irq_q   <= irq_d;
    end
  end

`ifdef GAME_FALL_EVENT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fall_q <= '0;
    else        fall_q <= fall_d;
  end
`endif

  always_comb begin
    event_count = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) event_count[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  always_comb begin
    status_word = '0;
    status_word[0 +: NUM_CH] = level_q;
    status_word[8 +: NUM_CH] = rise_q;
`ifdef GAME_FALL_EVENT_EN
    status_word[16 +: NUM_CH] = fall_q;
`endif
    status_word[31:24] = 8'(cnt_q[0]);
  end

  assign level     = level_q;
  assign rise_flag = rise_q;
  assign irq       = irq_q;

endmodule
